load_store_unit: RTL

Data-memory access stage for the RISC-V CPU, downstream of the controller: consumes its `Load`, `Store` and `MemWrite` decode plus the ALU address and register write data. It drives a request/acknowledge data-memory port with byte enables and lane-aligned write data, and returns sign- or zero-extended load data. While an access is in flight it asserts `Stall`, which freezes the PC and register-file write.

---
 rtl/lsu_pkg.sv | 59 +++++
 rtl/lsu_align.sv | 57 +++++
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - funct3 load codes and store size codes as decoded by the controller
//   - internal access-size encoding and byte-enable base patterns
//   - FSM state type (IDLE, BUSY, DONE)
//   - helpers mapping a request onto its access size and offset mask
package lsu_pkg;

  // Load types (funct3).
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Store sizes.
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Internal access size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte-enable patterns before shifting by the lane offset.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Loads and stores share the low two bits as the size field; any code
  // that is not byte or half (including reserved ones) is a word access.
  function automatic logic [1:0] access_size(input logic       is_store,
                                             input logic [2:0] ld,
                                             input logic [1:0] st);
    logic [1:0] code;
    code = is_store ? st : ld[1:0];
    case (code)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Address bits that survive alignment for a given access size.
  function automatic logic [1:0] offset_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'b11;
      SZ_HALF: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Write side: size_i/wr_off_i/wdata_i -> be_o (byte enables) and wdata_o
//   (data replicated across every lane the access could occupy).
// Read side: ld_type_i/rd_off_i/rdata_i -> rdata_o, the selected byte or
//   half, sign- or zero-extended; lw and reserved codes pass the word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  wr_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  rd_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE << wr_off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = BE_HALF << wr_off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
      end
    endcase
  end

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Bring the addressed lane down to bit 0 before extension.
    shifted = rdata_i >> {rd_off_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = shifted[15:0];
    case (ld_type_i)
      LD_LB:   rdata_o = {{24{byte_v[7]}}, byte_v};
      LD_LH:   rdata_o = {{16{half_v[15]}}, half_v};
      LD_LBU:  rdata_o = {24'd0, byte_v};
      LD_LHU:  rdata_o = {16'd0, half_v};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage of the RISC-V core.
// Inputs : clk, reset_n (async, active low), MemRead, MemWrite, Load[2:0],
//          Store[1:0], ALUResult[31:0] (byte address), WriteData[31:0],
//          mem_ack, mem_rdata[31:0].
// Outputs: ReadData[31:0], Stall, MisalignedFault, BusFault, mem_req, mem_we,
//          mem_addr[31:0], mem_be[3:0], mem_wdata[31:0], dbg_state_o (FSM).
// Parameter TIMEOUT: BUSY cycles to wait for mem_ack before aborting (0 = off).
// Macro LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses are refused and
//   flagged on MisalignedFault; otherwise they are silently aligned down.
//
// Handshake: mem_req rises on entry to BUSY with mem_we/addr/be/wdata stable
// and held until mem_ack is seen high on a rising edge while in BUSY; mem_rdata
// is sampled on that same edge. mem_ack at any other time is ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Load,
  input  logic [1:0]  Store,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignedFault,
  output logic        BusFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  dbg_state_o
);

  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        access, is_store, legal, start, timeout;
  logic [1:0]  size, req_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  logic [31:0] wd_cnt_q;
  logic [2:0]  ld_type_q;
  logic [1:0]  ld_off_q;
  logic        is_load_q;
  logic [31:0] read_data_q;
  logic        bus_fault_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  // A simultaneous read and write request is treated as a store.
  assign access   = MemRead | MemWrite;
  assign is_store = MemWrite;
  assign size     = access_size(is_store, Load, Store);
  // Offset after clearing the bits below the access size; for a legal
  // access this equals the raw address offset.
  assign req_off  = ALUResult[1:0] & offset_mask(size);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned, trap_now;
  assign misaligned = ((size == SZ_HALF) & ALUResult[0]) |
                      ((size == SZ_WORD) & (|ALUResult[1:0]));
  assign legal      = ~misaligned;
  assign trap_now   = (state_q == LSU_IDLE) & access & misaligned;
  assign MisalignedFault = reset_n & trap_now;
`else
  assign legal           = 1'b1;
  assign MisalignedFault = 1'b0;
`endif

  assign start   = (state_q == LSU_IDLE) & access & legal;
  assign timeout = (TIMEOUT != 0) && (state_q == LSU_BUSY) && !mem_ack &&
                   (wd_cnt_q == WD_LIMIT);

  lsu_align u_align (
    .size_i    (size),
    .wr_off_i  (req_off),
    .wdata_i   (WriteData),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ld_type_i (ld_type_q),
    .rd_off_i  (ld_off_q),
    .rdata_i   (mem_rdata),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LSU_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (start) state_d = LSU_BUSY;
      LSU_BUSY: begin
        if (mem_ack)      state_d = LSU_DONE;
        else if (timeout) state_d = LSU_IDLE;
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q    <= '0;
      ld_type_q   <= '0;
      ld_off_q    <= '0;
      is_load_q   <= 1'b0;
      read_data_q <= '0;
      bus_fault_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      bus_fault_q <= timeout;

      if (start) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= is_store;
        mem_addr_q  <= {ALUResult[31:2], 2'b00};
        mem_be_q    <= al_be;
        mem_wdata_q <= al_wdata;
        ld_type_q   <= Load;
        ld_off_q    <= req_off;
        is_load_q   <= ~is_store;
        wd_cnt_q    <= '0;
      end else if (state_q == LSU_BUSY) begin
        if (mem_ack || timeout) begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
        wd_cnt_q <= wd_cnt_q + 32'd1;
      end

      // Stores leave ReadData untouched so the last load result persists.
      if ((state_q == LSU_BUSY) && mem_ack && is_load_q) read_data_q <= al_rdata;
      else if (timeout)                                  read_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      else if (trap_now)                                 read_data_q <= '0;
`endif
    end
  end

  // Gating with reset_n keeps Stall at 0 while reset is held, even if the
  // controller is still presenting an access.
  assign Stall       = reset_n & (start | (state_q == LSU_BUSY));
  assign ReadData    = read_data_q;
  assign BusFault    = bus_fault_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;

endmodule
